// File: rtl/t09_button_pkg.sv
// Shared types and defaults for the multi-channel button front end.
// Optional auto-repeat is controlled by the T09_BUTTON_REPEAT_EN macro
// (see t09_debounce_channel).
package t09_button_pkg;

  typedef enum logic [1:0] {
    EDGE_PRESS   = 2'd0,
    EDGE_RELEASE = 2'd1,
    EDGE_BOTH    = 2'd2
  } edge_mode_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_DB_CYCLES     = 16;
  localparam int DEF_REPEAT_DELAY  = 500000;
  localparam int DEF_REPEAT_PERIOD = 100000;

  // Unknown edge-mode codes fall back to press-only, so press is enabled
  // for every code except the release-only one.
  function automatic logic press_enabled(input int mode);
    return (mode != int'(EDGE_RELEASE));
  endfunction

  function automatic logic release_enabled(input int mode);
    return (mode == int'(EDGE_RELEASE)) || (mode == int'(EDGE_BOTH));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/t09_debounce_channel.sv
// One button channel: synchroniser chain, debounce counter, edge pulse.
// With T09_BUTTON_REPEAT_EN defined, a held press also produces periodic
// auto-repeat pulses (first after REPEAT_DELAY, then every REPEAT_PERIOD).
module t09_debounce_channel
  import t09_button_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int EDGE_MODE     = int'(EDGE_PRESS),
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic nRst_i,
  input  logic button_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int                CNT_W      = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_TC     = CNT_W'(DB_CYCLES - 1);
  localparam logic              PRESS_EN   = press_enabled(EDGE_MODE);
  localparam logic              RELEASE_EN = release_enabled(EDGE_MODE);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("t09_debounce_channel: SYNC_STAGES must be 2..4");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("t09_debounce_channel: DB_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("t09_debounce_channel: REPEAT_DELAY/REPEAT_PERIOD must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pulse;

  logic w_sync;
  logic w_mismatch;
  logic w_flip;
  logic w_edge_hit;
  logic w_repeat_hit;

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_sync != r_level);
  assign w_flip     = w_mismatch && (r_cnt == CNT_TC);
  // Direction of the flip is the new level: 1 = press, 0 = release.
  assign w_edge_hit = w_flip && (w_sync ? PRESS_EN : RELEASE_EN);

  // Metastability chain: raw pin enters at bit 0, settled value leaves the top.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], button_i};
  end

  // Count consecutive mismatching cycles; any matching cycle restarts the window.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (!w_mismatch) begin
      r_cnt   <= '0;
    end else if (w_flip) begin
      r_level <= w_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

`ifdef T09_BUTTON_REPEAT_EN
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  logic [RPT_W-1:0] r_rpt;

  // Repeat fires at terminal count while held; a flip on the same edge wins,
  // so a release never coincides with a stray repeat.
  assign w_repeat_hit = PRESS_EN && r_level && !w_flip && (r_rpt == '0);

  // Hold down-counter: loaded on press, reloaded per repeat, cleared on release.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      r_rpt <= '0;
    end else if (w_flip) begin
      r_rpt <= w_sync ? RPT_W'(REPEAT_DELAY - 1) : '0;
    end else if (r_level) begin
      r_rpt <= (r_rpt == '0) ? RPT_W'(REPEAT_PERIOD - 1) : r_rpt - 1'b1;
    end
  end
`else
  assign w_repeat_hit = 1'b0;
`endif

  // Event pulse is registered so it lines up with the level flip.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) r_pulse <= 1'b0;
    else         r_pulse <= w_edge_hit | w_repeat_hit;
  end

  assign level_o = r_level;
  assign pulse_o = r_pulse;

endmodule

// File: rtl/t09_button_debounce_edge.sv
// Multi-channel push-button front end: N_CH independent debounce channels
// plus an any-event summary. Auto-repeat is enabled by defining
// T09_BUTTON_REPEAT_EN (handled inside t09_debounce_channel).
module t09_button_debounce_edge
  import t09_button_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int EDGE_MODE     = int'(EDGE_PRESS),
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            nRst_i,
  input  logic [N_CH-1:0] button_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] pulse_o,
  output logic            any_pulse_o
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    t09_debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .EDGE_MODE    (EDGE_MODE),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .nRst_i  (nRst_i),
      .button_i(button_i[g]),
      .level_o (level_o[g]),
      .pulse_o (pulse_o[g])
    );
  end

  assign any_pulse_o = |pulse_o;

endmodule

// File: tb/tb_t09_button_debounce_edge.sv
// Bench for t09_button_debounce_edge: three instances (press, release, both)
// share clock, reset and buttons; each is checked against a sample-history
// reference model, a vector table and a few hand-written sequences.
module tb_t09_button_debounce_edge;

  localparam int NC  = 4;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  logic          clk;
  logic          nRst_i;
  logic [NC-1:0] button;
  logic [NC-1:0] lvl_o [3];
  logic [NC-1:0] pul_o [3];
  logic          any_o [3];

  int total = 0;
  int bad   = 0;

  t09_button_debounce_edge #(.N_CH(NC), .SYNC_STAGES(SS), .DB_CYCLES(DB), .EDGE_MODE(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_press (
    .clk(clk), .nRst_i(nRst_i), .button_i(button),
    .level_o(lvl_o[0]), .pulse_o(pul_o[0]), .any_pulse_o(any_o[0]));

  t09_button_debounce_edge #(.N_CH(NC), .SYNC_STAGES(SS), .DB_CYCLES(DB), .EDGE_MODE(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_release (
    .clk(clk), .nRst_i(nRst_i), .button_i(button),
    .level_o(lvl_o[1]), .pulse_o(pul_o[1]), .any_pulse_o(any_o[1]));

  t09_button_debounce_edge #(.N_CH(NC), .SYNC_STAGES(SS), .DB_CYCLES(DB), .EDGE_MODE(2),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_both (
    .clk(clk), .nRst_i(nRst_i), .button_i(button),
    .level_o(lvl_o[2]), .pulse_o(pul_o[2]), .any_pulse_o(any_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_q holds raw button samples, newest first. The level flips when the
  // DB samples that have come out of the synchroniser all disagree with it.
  logic [NC-1:0] m_q [$];
  logic [NC-1:0] m_level;
  logic [NC-1:0] m_pulse [3];
  int            m_hold [NC];

  function automatic void model_reset();
    m_q.delete();
    for (int j = 0; j < SS + DB; j++) m_q.push_back('0);
    m_level = '0;
    for (int m = 0; m < 3; m++) m_pulse[m] = '0;
    for (int c = 0; c < NC; c++) m_hold[c] = 0;
  endfunction

  function automatic void model_step(input logic [NC-1:0] b);
    logic all_diff;
    m_q.push_front(b);
    for (int m = 0; m < 3; m++) m_pulse[m] = '0;
    for (int c = 0; c < NC; c++) begin
      all_diff = 1'b1;
      for (int j = SS; j < SS + DB; j++)
        if (m_q[j][c] == m_level[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[c]    = ~m_level[c];
        m_pulse[0][c] = m_level[c];
        m_pulse[1][c] = ~m_level[c];
        m_pulse[2][c] = 1'b1;
        m_hold[c]     = 0;
      end else if (m_level[c]) begin
        m_hold[c]++;
`ifdef T09_BUTTON_REPEAT_EN
        if (m_hold[c] >= RD && ((m_hold[c] - RD) % RP) == 0) begin
          m_pulse[0][c] = 1'b1;
          m_pulse[2][c] = 1'b1;
        end
`endif
      end
    end
    void'(m_q.pop_back());
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  // One clock: present b, let the edge happen, then compare all instances.
  task automatic tick(input logic [NC-1:0] b);
    button = b;
    @(posedge clk);
    #1;
    model_step(b);
    for (int m = 0; m < 3; m++) begin
      check($sformatf("model_level_m%0d", m), lvl_o[m], m_level);
      check($sformatf("model_pulse_m%0d", m), pul_o[m], m_pulse[m]);
      check($sformatf("model_any_m%0d", m), {3'b000, any_o[m]}, {3'b000, |m_pulse[m]});
    end
  endtask

  task automatic check_all_zero(input string nm);
    for (int m = 0; m < 3; m++) begin
      check({nm, "_level"}, lvl_o[m], '0);
      check({nm, "_pulse"}, pul_o[m], '0);
      check({nm, "_any"}, {3'b000, any_o[m]}, 4'b0000);
    end
  endtask

  // Reset from a point away from the clock edge; outputs must clear at once.
  task automatic do_reset(input string nm);
    #2;
    nRst_i = 1'b0;
    #1;
    check_all_zero(nm);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRst_i = 1'b1;
  endtask

  typedef struct {
    logic [NC-1:0] btn;
    logic [NC-1:0] lvl;
    logic [NC-1:0] p_press;
    logic [NC-1:0] p_rel;
    logic [NC-1:0] p_both;
  } vec_t;

  vec_t tv [16];
  int   pulse_ticks [$];
  int   exp_ticks [$];
  int   cnt_a, cnt_b;
  logic [NC-1:0] seen;
  logic [NC-1:0] rnd_btn;
  int   rate;

  initial begin
    // Clean press of ch0 sampled on edge 1, released from edge 9.
    tv[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[1]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[2]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[3]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    tv[6]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tv[7]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tv[8]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tv[9]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tv[10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tv[11] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tv[12] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tv[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    tv[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    nRst_i = 1'b0;
    button = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    nRst_i = 1'b1;

    // Table: clean press / release under all three edge modes.
    for (int i = 0; i < 16; i++) begin
      tick(tv[i].btn);
      check($sformatf("tbl%0d_level", i + 1), lvl_o[0], tv[i].lvl);
      check($sformatf("tbl%0d_press", i + 1), pul_o[0], tv[i].p_press);
      check($sformatf("tbl%0d_release", i + 1), pul_o[1], tv[i].p_rel);
      check($sformatf("tbl%0d_both", i + 1), pul_o[2], tv[i].p_both);
      check($sformatf("tbl%0d_any", i + 1), {3'b000, any_o[0]}, {3'b000, |tv[i].p_press});
    end

    // Bounce on ch1: 3 high, 1 low, 3 high, then low -- never long enough.
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      tick((i < 7 && i != 3) ? 4'b0010 : 4'b0000);
      for (int m = 0; m < 3; m++) seen = seen | lvl_o[m] | pul_o[m];
    end
    check("bounce_ch1_never", seen & 4'b0010, 4'b0000);

    // Reset mid-count: ch0 already pressed, ch2 counting when reset hits.
    repeat (8) tick(4'b0001);
    check("pre_reset_level", lvl_o[0], 4'b0001);
    repeat (4) tick(4'b0101);
    do_reset("mid_count_reset");
    for (int i = 1; i <= 6; i++) begin
      tick(4'b0101);
      if (i == 5) check("post_reset_edge5_level", lvl_o[0], 4'b0000);
      if (i == 6) begin
        check("post_reset_edge6_level", lvl_o[0], 4'b0101);
        check("post_reset_edge6_pulse", pul_o[0], 4'b0101);
      end
    end
    repeat (10) tick(4'b0000);

    // Simultaneous press of all channels, then simultaneous release.
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b1111);
      if (pul_o[0] == 4'b1111) cnt_a++;
      else if (pul_o[0] != 4'b0000) cnt_b++;
    end
    check("simul_press_count", 4'(cnt_a), 4'd1);
    check("simul_press_partial", 4'(cnt_b), 4'd0);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000);
      if (pul_o[0] != 4'b0000) cnt_a++;
      if (pul_o[1] == 4'b1111) cnt_b++;
    end
    check("simul_release_press_mode", 4'(cnt_a), 4'd0);
    check("simul_release_rel_mode", 4'(cnt_b), 4'd1);

    // Long hold of ch0: press pulse at edge 6, then auto-repeats if built in.
    pulse_ticks.delete();
    for (int i = 1; i <= 28; i++) begin
      tick(4'b0001);
      if (pul_o[0][0]) pulse_ticks.push_back(i);
    end
`ifdef T09_BUTTON_REPEAT_EN
    exp_ticks = '{6, 16, 21, 26};
`else
    exp_ticks = '{6};
`endif
    check("hold_pulse_count", 4'(pulse_ticks.size()), 4'(exp_ticks.size()));
    for (int k = 0; k < exp_ticks.size() && k < pulse_ticks.size(); k++)
      check($sformatf("hold_pulse_tick%0d", k), 4'(pulse_ticks[k]), 4'(exp_ticks[k]));
    seen = '0;
    for (int i = 29; i <= 44; i++) begin
      tick(4'b0000);
      if (i > 33) seen = seen | pul_o[0];
    end
    check("hold_release_no_repeat", seen, 4'b0000);

    // Randomised stimulus: alternate bouncy and calm stretches, with resets.
    rnd_btn = '0;
    rate = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rate = (rate == 30) ? 3 : 30;
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 99) < rate) rnd_btn[c] = ~rnd_btn[c];
      tick(rnd_btn);
      if (i % 750 == 749) do_reset("rand_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
